rx_link_ctrl: RTL and testbench
===============================

Name: rx_link_ctrl

Overview:
- Link-level receive controller between the 10-bit deserializer/descrambler output and the display/payload consumers.
- Hunts for a framing sync word and pulses the deserializer's bitslip input until word alignment is found.
- Declares lock after repeated good syncs, drops lock after repeated misses.
- Forwards payload words, latches one display word per frame, and keeps link-quality counters.

Parameters:
- SYNC_WORD, 10'h17C, framing word expected in frame slot 0.
- FRAME_LEN, 16, words per frame including the sync slot; legal values 2..256.
- LOCK_CNT, 4, consecutive good syncs needed to declare lock; legal values 1..15.
- UNLOCK_CNT, 3, consecutive missed syncs while locked that drop lock; legal values 1..15.
- SLIP_WAIT_CYC, 8, rclk cycles to ignore din after a bitslip pulse; legal values 1..255.

Ports:
- rclk  in  1  receive word clock; all logic is in this single clock domain.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  din carries a new word this cycle.
- din  in  10  descrambled parallel word.
- bitslip  out  1  one-cycle pulse telling the deserializer to shift alignment by one bit.
- locked  out  1  link is frame-locked.
- state  out  2  current FSM state: HUNT=0, SLIP=1, CHECK=2, LOCKED=3.
- pay_valid  out  1  pay_word is valid this cycle.
- pay_word  out  10  forwarded payload word.
- disp_word  out  10  latched display word.
- disp_valid  out  1  one-cycle pulse when disp_word updates.
- sync_err_cnt  out  16  count of sync misses while LOCKED; saturates.
- lock_loss_cnt  out  8  count of LOCKED-to-HUNT transitions; saturates.

Behaviour:
- Outputs: all outputs are registered. On rst, every output is 0 and state=HUNT, and all internal counters clear.
- Reset timing: rst takes effect at the next rclk edge in any state, including mid-slip-wait, and overrides all other events.
- "Word event" means a cycle with din_valid=1. When din_valid=0, nothing changes except the SLIP wait counter.
- Frame position: pos counts 0..FRAME_LEN-1, advances one per word event, and wraps to 0. Slot 0 is the sync slot.
- HUNT:
  - Word event with din==SYNC_WORD: set good=1 and pos=1. If LOCK_CNT==1, go to LOCKED; otherwise go to CHECK.
  - Word event with a mismatch: increment hunt_cnt. When hunt_cnt reaches FRAME_LEN, drive bitslip=1 for the next cycle only, clear hunt_cnt, and go to SLIP.
- SLIP:
  - Ignore din.
  - Count SLIP_WAIT_CYC rclk cycles from the cycle after the bitslip pulse, regardless of din_valid.
  - Then go to HUNT with hunt_cnt=0.
- CHECK:
  - Word event at pos 0, match: increment good. If good reaches LOCK_CNT, go to LOCKED; locked=1 is visible one cycle after that sync word is sampled.
  - Word event at pos 0, mismatch: go to HUNT with hunt_cnt=0 and good=0.
  - No payload is forwarded in CHECK.
- LOCKED:
  - Word event at pos 0, match: clear miss.
  - Word event at pos 0, mismatch: increment miss and sync_err_cnt.
  - If miss reaches UNLOCK_CNT: go to HUNT, set locked=0 the next cycle, increment lock_loss_cnt, clear miss and hunt_cnt. The mismatching word is not re-examined as a hunt candidate.
  - Word event at pos!=0: the next cycle has pay_valid=1 and pay_word=din.
  - Word event at pos 1: additionally disp_word<=din and disp_valid=1 for one cycle. disp_word holds its value through unlock.
- Latency: every response appears exactly one rclk cycle after the word event that caused it.
- Saturation: sync_err_cnt stops at 16'hFFFF and lock_loss_cnt stops at 8'hFF; neither wraps.
- Simultaneous events: bitslip never asserts outside HUNT→SLIP. The pos wrap and the sync check occur in the same cycle without conflict.

Test Plan:
- Aligned stream, SYNC_WORD every 16th word starting at word 0, payload=word index, continuous din_valid → locked rises the cycle after word 48 is sampled. First disp_valid follows word 49 with disp_word=10'd49. pay_valid is never high before lock.
- 16 words of 10'h000 in HUNT → bitslip high exactly one cycle after the 16th word, state=SLIP for 8 cycles. A SYNC_WORD presented during SLIP is ignored, then state returns to HUNT.
- Locked link, corrupt 2 consecutive sync slots, then a good sync → locked stays 1, sync_err_cnt=2, lock_loss_cnt=0. Then corrupt 3 consecutive sync slots → locked falls the cycle after the 3rd, lock_loss_cnt=1, sync_err_cnt=5.
- False SYNC_WORD in HUNT followed by 10'h000 at the pos-0 slot 16 words later → state goes CHECK then HUNT, locked never asserts.
- Aligned stream with din_valid toggling every cycle → identical lock and display behaviour counted in word events; lock occurs after the 49th valid word (about 98 cycles).
- rst asserted for one cycle while LOCKED with counters nonzero → at the next edge all outputs are 0 and state=HUNT. A re-lock then takes the same time as the first test.

Source files
------------

// File: rtl/rx_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rx_link_ctrl
// Description : Receive link controller. Hunts for word alignment via bitslip,
//               frame-locks on a sync word, forwards payload, keeps counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_link_ctrl #(
    parameter logic [9:0] SYNC_WORD     = 10'h17C,
    parameter int         FRAME_LEN     = 16,
    parameter int         LOCK_CNT      = 4,
    parameter int         UNLOCK_CNT    = 3,
    parameter int         SLIP_WAIT_CYC = 8
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        din_valid,
    input  logic [9:0]  din,
    output logic        bitslip,
    output logic        locked,
    output logic [1:0]  state,
    output logic        pay_valid,
    output logic [9:0]  pay_word,
    output logic [9:0]  disp_word,
    output logic        disp_valid,
    output logic [15:0] sync_err_cnt,
    output logic [7:0]  lock_loss_cnt
);

    localparam int                  c_pos_w      = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int                  c_hunt_w     = $clog2(FRAME_LEN + 1);
    localparam logic [c_pos_w-1:0]  c_pos_last   = c_pos_w'(FRAME_LEN - 1);
    localparam logic [c_pos_w-1:0]  c_pos_one    = c_pos_w'(1);
    localparam logic [c_hunt_w-1:0] c_hunt_max   = c_hunt_w'(FRAME_LEN);
    localparam logic [3:0]          c_lock_cnt   = 4'(LOCK_CNT);
    localparam logic [3:0]          c_unlock_cnt = 4'(UNLOCK_CNT);
    localparam logic [7:0]          c_slip_last  = 8'(SLIP_WAIT_CYC - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SLIP   = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_pos_w-1:0]  pos_q, pos_d;
    logic [c_hunt_w-1:0] hunt_cnt_q, hunt_cnt_d;
    logic [3:0]          good_q, good_d;
    logic [3:0]          miss_q, miss_d;
    logic [7:0]          slip_cnt_q, slip_cnt_d;
    logic                bitslip_q, bitslip_d;
    logic                locked_q, locked_d;
    logic                pay_valid_q, pay_valid_d;
    logic [9:0]          pay_word_q, pay_word_d;
    logic [9:0]          disp_word_q, disp_word_d;
    logic                disp_valid_q, disp_valid_d;
    logic [15:0]         sync_err_cnt_q, sync_err_cnt_d;
    logic [7:0]          lock_loss_cnt_q, lock_loss_cnt_d;

    logic                w_is_sync;
    logic                w_at_slot0;
    logic [c_pos_w-1:0]  w_pos_next;

    assign w_is_sync  = (din == SYNC_WORD);
    assign w_at_slot0 = (pos_q == '0);
    assign w_pos_next = (pos_q == c_pos_last) ? '0 : pos_q + 1'b1;

    always_comb begin
        state_d         = state_q;
        pos_d           = pos_q;
        hunt_cnt_d      = hunt_cnt_q;
        good_d          = good_q;
        miss_d          = miss_q;
        slip_cnt_d      = slip_cnt_q;
        bitslip_d       = 1'b0;
        pay_valid_d     = 1'b0;
        pay_word_d      = pay_word_q;
        disp_word_d     = disp_word_q;
        disp_valid_d    = 1'b0;
        sync_err_cnt_d  = sync_err_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;

        case (state_q)
            HUNT: begin
                if (din_valid) begin
                    if (w_is_sync) begin
                        good_d     = 4'd1;
                        miss_d     = 4'd0;
                        pos_d      = c_pos_one;
                        hunt_cnt_d = '0;
                        state_d    = (LOCK_CNT == 1) ? LOCKED : CHECK;
                    end else if (hunt_cnt_q + 1'b1 == c_hunt_max) begin
                        bitslip_d  = 1'b1;
                        hunt_cnt_d = '0;
                        slip_cnt_d = 8'd0;
                        state_d    = SLIP;
                    end else begin
                        hunt_cnt_d = hunt_cnt_q + 1'b1;
                    end
                end
            end
            // SLIP is visible for SLIP_WAIT_CYC cycles, the first one carrying the pulse.
            SLIP: begin
                if (slip_cnt_q == c_slip_last) begin
                    hunt_cnt_d = '0;
                    state_d    = HUNT;
                end else begin
                    slip_cnt_d = slip_cnt_q + 8'd1;
                end
            end
            CHECK: begin
                if (din_valid) begin
                    pos_d = w_pos_next;
                    if (w_at_slot0) begin
                        if (w_is_sync) begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 == c_lock_cnt) begin
                                miss_d  = 4'd0;
                                state_d = LOCKED;
                            end
                        end else begin
                            good_d     = 4'd0;
                            hunt_cnt_d = '0;
                            state_d    = HUNT;
                        end
                    end
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    pos_d = w_pos_next;
                    if (w_at_slot0) begin
                        if (w_is_sync) begin
                            miss_d = 4'd0;
                        end else begin
                            if (sync_err_cnt_q != 16'hFFFF) begin
                                sync_err_cnt_d = sync_err_cnt_q + 16'd1;
                            end
                            if (miss_q + 4'd1 == c_unlock_cnt) begin
                                miss_d     = 4'd0;
                                hunt_cnt_d = '0;
                                state_d    = HUNT;
                                if (lock_loss_cnt_q != 8'hFF) begin
                                    lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                                end
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end
                    end else begin
                        pay_valid_d = 1'b1;
                        pay_word_d  = din;
                        if (pos_q == c_pos_one) begin
                            disp_word_d  = din;
                            disp_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_q         <= HUNT;
            pos_q           <= '0;
            hunt_cnt_q      <= '0;
            good_q          <= 4'd0;
            miss_q          <= 4'd0;
            slip_cnt_q      <= 8'd0;
            bitslip_q       <= 1'b0;
            locked_q        <= 1'b0;
            pay_valid_q     <= 1'b0;
            pay_word_q      <= 10'd0;
            disp_word_q     <= 10'd0;
            disp_valid_q    <= 1'b0;
            sync_err_cnt_q  <= 16'd0;
            lock_loss_cnt_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            pos_q           <= pos_d;
            hunt_cnt_q      <= hunt_cnt_d;
            good_q          <= good_d;
            miss_q          <= miss_d;
            slip_cnt_q      <= slip_cnt_d;
            bitslip_q       <= bitslip_d;
            locked_q        <= locked_d;
            pay_valid_q     <= pay_valid_d;
            pay_word_q      <= pay_word_d;
            disp_word_q     <= disp_word_d;
            disp_valid_q    <= disp_valid_d;
            sync_err_cnt_q  <= sync_err_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign bitslip       = bitslip_q;
    assign locked        = locked_q;
    assign state         = state_q;
    assign pay_valid     = pay_valid_q;
    assign pay_word      = pay_word_q;
    assign disp_word     = disp_word_q;
    assign disp_valid    = disp_valid_q;
    assign sync_err_cnt  = sync_err_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rx_link_ctrl
// Description : Self-checking bench for rx_link_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_link_ctrl;

    localparam logic [9:0] SYNC = 10'h17C;
    localparam int FL = 16;
    localparam int LC = 4;
    localparam int UC = 3;
    localparam int SW = 8;

    logic        rclk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic [9:0]  din;
    logic        bitslip;
    logic        locked;
    logic [1:0]  state;
    logic        pay_valid;
    logic [9:0]  pay_word;
    logic [9:0]  disp_word;
    logic        disp_valid;
    logic [15:0] sync_err_cnt;
    logic [7:0]  lock_loss_cnt;

    rx_link_ctrl #(
        .SYNC_WORD    (SYNC),
        .FRAME_LEN    (FL),
        .LOCK_CNT     (LC),
        .UNLOCK_CNT   (UC),
        .SLIP_WAIT_CYC(SW)
    ) dut (
        .rclk         (rclk),
        .rst          (rst),
        .din_valid    (din_valid),
        .din          (din),
        .bitslip      (bitslip),
        .locked       (locked),
        .state        (state),
        .pay_valid    (pay_valid),
        .pay_word     (pay_word),
        .disp_word    (disp_word),
        .disp_valid   (disp_valid),
        .sync_err_cnt (sync_err_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 rclk = ~rclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0=hunting, 1=slip wait, 2=checking, 3=locked.
    int         m_st, m_pos, m_hunt, m_good, m_miss, m_wait, m_serr, m_lloss;
    bit         m_bs, m_pv, m_dv;
    logic [9:0] m_pw, m_dw;

    int         wcount, lock_at, disp_at;
    logic [9:0] disp_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [9:0] d);
        m_bs = 0;
        m_pv = 0;
        m_dv = 0;
        if (r) begin
            m_st = 0; m_pos = 0; m_hunt = 0; m_good = 0; m_miss = 0; m_wait = 0;
            m_serr = 0; m_lloss = 0; m_pw = '0; m_dw = '0;
        end else if (m_st == 1) begin
            m_wait++;
            if (m_wait == SW) begin
                m_st   = 0;
                m_hunt = 0;
            end
        end else if (v) begin
            if (m_st == 0) begin
                if (d == SYNC) begin
                    m_good = 1; m_miss = 0; m_pos = 1; m_hunt = 0;
                    m_st   = (LC == 1) ? 3 : 2;
                end else begin
                    m_hunt++;
                    if (m_hunt == FL) begin
                        m_bs = 1; m_hunt = 0; m_wait = 0; m_st = 1;
                    end
                end
            end else begin
                bit slot0;
                slot0 = (m_pos == 0);
                m_pos = (m_pos + 1) % FL;
                if (m_st == 2 && slot0) begin
                    if (d == SYNC) begin
                        m_good++;
                        if (m_good == LC) begin
                            m_st = 3; m_miss = 0;
                        end
                    end else begin
                        m_st = 0; m_hunt = 0; m_good = 0;
                    end
                end else if (m_st == 3 && slot0) begin
                    if (d == SYNC) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_serr < 65535) m_serr++;
                        if (m_miss == UC) begin
                            m_st = 0; m_miss = 0; m_hunt = 0;
                            if (m_lloss < 255) m_lloss++;
                        end
                    end
                end else if (m_st == 3) begin
                    m_pv = 1;
                    m_pw = d;
                    if ((m_pos + FL - 1) % FL == 1) begin
                        m_dv = 1;
                        m_dw = d;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [9:0] d);
        logic [63:0] obs, exp;
        rst       = r;
        din_valid = v;
        din       = d;
        @(posedge rclk);
        model_step(r, v, d);
        #1;
        obs = 64'({state, locked, bitslip, pay_valid, (m_pv ? pay_word : 10'h0),
                   disp_word, disp_valid, sync_err_cnt, lock_loss_cnt});
        exp = 64'({2'(m_st), (m_st == 3), m_bs, m_pv, (m_pv ? m_pw : 10'h0),
                   m_dw, m_dv, 16'(m_serr), 8'(m_lloss)});
        check("model", obs, exp);
        if (r) begin
            wcount  = 0;
            lock_at = -1;
            disp_at = -1;
        end else if (v) begin
            if (locked && lock_at < 0) lock_at = wcount;
            if (disp_valid && disp_at < 0) begin
                disp_at  = wcount;
                disp_val = disp_word;
            end
            wcount++;
        end
    endtask

    // One frame: sync slot (good or corrupted) then payload words.
    task automatic frame(input bit good, input bit toggle, input bit rnd);
        logic [9:0] d;
        for (int j = 0; j < FL; j++) begin
            if (j == 0) d = good ? SYNC : 10'h000;
            else if (rnd) d = 10'($urandom);
            else d = wcount[9:0];
            cycle(0, 1, d);
            if (toggle) cycle(0, 0, 10'($urandom));
        end
    endtask

    task automatic reset_dut();
        cycle(1, 0, 10'h000);
        cycle(0, 0, 10'h000);
    endtask

    initial begin
        logic [9:0] rw;
        m_pw = '0; m_dw = '0;
        wcount = 0; lock_at = -1; disp_at = -1; disp_val = '0;

        // Reset state
        cycle(1, 0, 10'h3FF);
        cycle(1, 1, SYNC);
        check("reset_outputs", 64'({state, locked, bitslip, pay_valid, pay_word, disp_word,
                                    disp_valid, sync_err_cnt, lock_loss_cnt}), 64'd0);

        // Aligned stream, payload = word index
        cycle(0, 0, 10'h000);
        for (int f = 0; f < 5; f++) frame(1, 0, 0);
        check("lock_word", 64'(lock_at), 64'd48);
        check("first_disp_word_idx", 64'(disp_at), 64'd49);
        check("first_disp_value", 64'(disp_val), 64'd49);

        // Two missed syncs tolerated, then three drop the lock
        frame(0, 0, 1);
        frame(0, 0, 1);
        frame(1, 0, 1);
        check("locked_after_2miss", 64'(locked), 64'd1);
        check("sync_err_2", 64'(sync_err_cnt), 64'd2);
        check("lock_loss_0", 64'(lock_loss_cnt), 64'd0);
        frame(0, 0, 0);
        frame(0, 0, 0);
        frame(0, 0, 0);
        check("unlocked_after_3miss", 64'(locked), 64'd0);
        check("lock_loss_1", 64'(lock_loss_cnt), 64'd1);
        check("sync_err_5", 64'(sync_err_cnt), 64'd5);

        // Re-lock, then a single-cycle reset while counters are nonzero
        for (int f = 0; f < 5; f++) frame(1, 0, 1);
        check("relocked", 64'(locked), 64'd1);
        cycle(1, 1, SYNC);
        check("reset_while_locked", 64'({state, locked, bitslip, pay_valid, pay_word, disp_word,
                                         disp_valid, sync_err_cnt, lock_loss_cnt}), 64'd0);
        for (int f = 0; f < 5; f++) frame(1, 0, 0);
        check("relock_word", 64'(lock_at), 64'd48);
        check("relock_disp_value", 64'(disp_val), 64'd49);

        // Sixteen misses trigger a single bitslip; SYNC during SLIP is ignored
        reset_dut();
        for (int i = 0; i < FL; i++) cycle(0, 1, 10'h000);
        check("bitslip_pulse", 64'(bitslip), 64'd1);
        check("slip_entered", 64'(state), 64'd1);
        for (int i = 1; i < SW; i++) begin
            cycle(0, 1, SYNC);
            check("slip_hold", 64'({state, bitslip}), 64'({2'd1, 1'b0}));
        end
        cycle(0, 1, SYNC);
        check("slip_exit_hunt", 64'(state), 64'd0);

        // False sync then a bad slot 0 sends CHECK back to HUNT
        reset_dut();
        cycle(0, 1, SYNC);
        check("false_sync_check", 64'(state), 64'd2);
        for (int i = 1; i < FL; i++) begin
            rw = 10'($urandom);
            if (rw == SYNC) rw = 10'h001;
            cycle(0, 1, rw);
        end
        cycle(0, 1, 10'h000);
        check("false_sync_back_hunt", 64'({state, locked}), 64'd0);

        // din_valid toggling: lock counted in word events
        reset_dut();
        for (int f = 0; f < 5; f++) frame(1, 1, 0);
        check("toggle_lock_word", 64'(lock_at), 64'd48);
        check("toggle_disp_value", 64'(disp_val), 64'd49);

        // Random aligned stream with occasional corrupted syncs and gaps
        reset_dut();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 4) == 0) cycle(0, 0, 10'($urandom));
            if (k % FL == 0 && $urandom_range(0, 5) != 0) rw = SYNC;
            else rw = 10'($urandom);
            cycle(0, 1, rw);
        end

        // Fully random traffic
        for (int k = 0; k < 600; k++) begin
            rw = ($urandom_range(0, 7) == 0) ? SYNC : 10'($urandom);
            cycle(0, ($urandom_range(0, 3) != 0), rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
